// File: rtl/idct_pkg.sv
// Shared definitions for the IDCT transpose buffer and its helpers.
//   IN_W / OUT_W : row-stage result width / column-stage lane width
//   SHIFT        : first-pass scaling shift applied after rounding
//   OUT_MAX/MIN  : saturation limits of a signed OUT_W lane
//   rd_state_t   : read FSM encoding
//   bank_st_t    : ping-pong bank occupancy
package idct_pkg;
  localparam int IN_W    = 24;
  localparam int OUT_W   = 16;
  localparam int SHIFT   = 7;
  localparam int OUT_MAX = 32767;
  localparam int OUT_MIN = -32768;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } rd_state_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_st_t;
endpackage

// File: rtl/idct_round_sat.sv
// Combinational round / arithmetic-shift / saturate of one signed sample.
// Ports:
//   d   : signed IN_W input sample
//   q   : signed OUT_W result, clamped to [OUT_MIN, OUT_MAX]
//   sat : result was clamped (only with IDCT_TRANSPOSE_SAT_FLAG_EN defined)
module idct_round_sat #(
  parameter int IN_W  = idct_pkg::IN_W,
  parameter int OUT_W = idct_pkg::OUT_W,
  parameter int SHIFT = idct_pkg::SHIFT
) (
  input  logic [IN_W-1:0]  d,
  output logic [OUT_W-1:0] q
`ifdef IDCT_TRANSPOSE_SAT_FLAG_EN
  ,
  output logic             sat
`endif
);
  // One extra bit of headroom so the rounding add cannot overflow.
  localparam logic signed [IN_W:0] RND  = (IN_W+1)'(2 ** (SHIFT - 1));
  localparam logic signed [IN_W:0] OMAX = (IN_W+1)'(idct_pkg::OUT_MAX);
  localparam logic signed [IN_W:0] OMIN = (IN_W+1)'(idct_pkg::OUT_MIN);

  logic signed [IN_W:0] sum;
  logic signed [IN_W:0] t;
  logic                 over;
  logic                 under;

  always_comb begin
    sum   = $signed({d[IN_W-1], d}) + RND;
    t     = sum >>> SHIFT;
    over  = (t > OMAX);
    under = (t < OMIN);
    if (over)
      q = OMAX[OUT_W-1:0];
    else if (under)
      q = OMIN[OUT_W-1:0];
    else
      q = t[OUT_W-1:0];
  end

`ifdef IDCT_TRANSPOSE_SAT_FLAG_EN
  assign sat = over | under;
`endif
endmodule

// File: rtl/idct_transpose_buf.sv
// Ping-pong 4x4 transpose buffer between the row and column IDCT passes.
// Samples arrive row-major, are rounded/shifted/saturated, and are read
// back one column per beat on four lanes.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid/in_ready   : input handshake, in_data is the IN_W row result
//   out_valid/out_ready : output handshake for one column beat
//   out_1..out_4        : rows 0..3 of the current column
//   out_col, out_last   : column index, high on column 3
//   sat_flag            : sticky saturation flag, present only when
//                         IDCT_TRANSPOSE_SAT_FLAG_EN is defined
//
// Read FSM:
//   state | meaning
//   IDLE  | read bank not yet full, lanes hold, out_valid low
//   SEND  | presenting column out_col of the read bank
module idct_transpose_buf #(
  parameter int SHIFT = idct_pkg::SHIFT,
  parameter int IN_W  = idct_pkg::IN_W,
  parameter int OUT_W = idct_pkg::OUT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_1,
  output logic [OUT_W-1:0] out_2,
  output logic [OUT_W-1:0] out_3,
  output logic [OUT_W-1:0] out_4,
  output logic [1:0]       out_col,
  output logic             out_last
`ifdef IDCT_TRANSPOSE_SAT_FLAG_EN
  ,
  output logic             sat_flag
`endif
);
  import idct_pkg::*;

  logic [OUT_W-1:0] mem [2][4][4];
  bank_st_t         status [2];
  logic             wr_bank;
  logic [3:0]       wr_idx;
  logic             rd_bank;
  rd_state_t        state;

  logic             accept;
  logic             rd_done;
  logic [OUT_W-1:0] conv;

  logic             ld_en;
  logic             ld_bank;
  logic [1:0]       ld_col;

  assign in_ready = (status[wr_bank] == EMPTY);
  assign accept   = in_valid && in_ready;
  assign rd_done  = (state == SEND) && out_ready && (out_col == 2'd3);

`ifdef IDCT_TRANSPOSE_SAT_FLAG_EN
  logic sample_sat;

  idct_round_sat #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_round_sat (
    .d   (in_data),
    .q   (conv),
    .sat (sample_sat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sat_flag <= 1'b0;
    else if (accept && sample_sat)
      sat_flag <= 1'b1;
  end
`else
  idct_round_sat #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_round_sat (
    .d (in_data),
    .q (conv)
  );
`endif

  // Storage carries no reset: a bank is only read after all 16 entries
  // have been rewritten since it was last emptied.
  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_bank][wr_idx[3:2]][wr_idx[1:0]] <= conv;
  end

  // Write side and bank occupancy. When both a fill and a free happen in
  // one cycle they necessarily target different banks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank   <= 1'b0;
      wr_idx    <= 4'd0;
      status[0] <= EMPTY;
      status[1] <= EMPTY;
    end else begin
      if (accept) begin
        wr_idx <= wr_idx + 4'd1;
        if (wr_idx == 4'd15) begin
          status[wr_bank] <= FULL;
          wr_bank         <= ~wr_bank;
        end
      end
      if (rd_done)
        status[rd_bank] <= EMPTY;
    end
  end

  // Which column (if any) gets loaded into the lane registers this cycle.
  // On the column-3 handshake the other bank is picked up directly so two
  // full banks stream without a gap.
  always_comb begin
    ld_en   = 1'b0;
    ld_bank = rd_bank;
    ld_col  = 2'd0;
    if (state == IDLE) begin
      ld_en = (status[rd_bank] == FULL);
    end else if (out_ready) begin
      if (out_col == 2'd3) begin
        ld_bank = ~rd_bank;
        ld_en   = (status[~rd_bank] == FULL);
      end else begin
        ld_en  = 1'b1;
        ld_col = out_col + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rd_bank   <= 1'b0;
      out_valid <= 1'b0;
      out_col   <= 2'd0;
      out_last  <= 1'b0;
      out_1     <= '0;
      out_2     <= '0;
      out_3     <= '0;
      out_4     <= '0;
    end else begin
      if (ld_en) begin
        out_1 <= mem[ld_bank][0][ld_col];
        out_2 <= mem[ld_bank][1][ld_col];
        out_3 <= mem[ld_bank][2][ld_col];
        out_4 <= mem[ld_bank][3][ld_col];
      end
      case (state)
        IDLE: begin
          if (ld_en) begin
            state     <= SEND;
            out_valid <= 1'b1;
            out_col   <= 2'd0;
            out_last  <= 1'b0;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (out_col == 2'd3) begin
              rd_bank  <= ~rd_bank;
              out_col  <= 2'd0;
              out_last <= 1'b0;
              if (!ld_en) begin
                state     <= IDLE;
                out_valid <= 1'b0;
              end
            end else begin
              out_col  <= ld_col;
              out_last <= (ld_col == 2'd3);
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_idct_transpose_buf.sv
module tb_idct_transpose_buf;
  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_1, out_2, out_3, out_4;
  logic [1:0]  out_col;
  logic        out_last;
`ifdef IDCT_TRANSPOSE_SAT_FLAG_EN
  logic        sat_flag;
`endif

  idct_transpose_buf dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_1     (out_1),
    .out_2     (out_2),
    .out_3     (out_3),
    .out_4     (out_4),
    .out_col   (out_col),
    .out_last  (out_last)
`ifdef IDCT_TRANSPOSE_SAT_FLAG_EN
    ,
    .sat_flag  (sat_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] din;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [63:0] lanes;
    logic [1:0]  col;
    logic        last;
  } col_t;

  int   passed = 0;
  int   total  = 0;
  col_t sb[$];
  logic [15:0] blk [16];
  int   blk_n   = 0;
  int   acc_cnt = 0;
  int   beats   = 0;
  int   low_cnt = 0;
  int   cyc     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] conv(input logic [23:0] d);
    longint n, q;
    n = longint'($signed(d)) + 64;
    if (n >= 0) q = n / 128;
    else q = -((-n + 127) / 128);
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset) begin
      if (!in_ready) low_cnt++;
      if (out_valid && out_ready) begin
        beats++;
        if (sb.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          col_t e;
          e = sb.pop_front();
          chk("col_lanes", {out_1, out_2, out_3, out_4}, e.lanes);
          chk("col_idx_last", {61'd0, out_col, out_last}, {61'd0, e.col, e.last});
        end
      end
    end
  end

  // Drives one sample; the expected lane value goes into the block model at
  // the moment the handshake is seen, and a finished block pushes 4 columns.
  task automatic send(input logic [23:0] d, input logic [15:0] e);
    int g;
    g = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      chk("in_accept_timeout", 64'd0, 64'd1);
    end else begin
      blk[blk_n] = e;
      blk_n++;
      acc_cnt++;
      if (blk_n == 16) begin
        for (int c = 0; c < 4; c++) begin
          col_t r;
          r.lanes = {blk[c], blk[4+c], blk[8+c], blk[12+c]};
          r.col   = 2'(c);
          r.last  = (c == 3);
          sb.push_back(r);
        end
        blk_n = 0;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while ((sb.size() != 0 || out_valid) && g < 400) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk(name, {63'd0, (sb.size() == 0 && !out_valid)}, 64'd1);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    chk({name, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({name, "_lanes"}, {out_1, out_2, out_3, out_4}, 64'd0);
    chk({name, "_col_last"}, {61'd0, out_col, out_last}, 64'd0);
`ifdef IDCT_TRANSPOSE_SAT_FLAG_EN
    chk({name, "_sat_flag"}, {63'd0, sat_flag}, 64'd0);
`endif
  endtask

  initial begin
    vec_t tbl [16];
    int   b0;
    int   c0;

    tbl[0]  = '{24'd8192,     16'd64};
    tbl[1]  = '{24'd8256,     16'd65};
    tbl[2]  = '{-24'sd100,    -16'sd1};
    tbl[3]  = '{-24'sd64,     16'd0};
    tbl[4]  = '{24'd63,       16'd0};
    tbl[5]  = '{24'h7FFFFF,   16'h7FFF};
    tbl[6]  = '{24'h800000,   16'h8000};
    tbl[7]  = '{24'd64,       16'd1};
    tbl[8]  = '{-24'sd65,     -16'sd1};
    tbl[9]  = '{24'd191,      16'd1};
    tbl[10] = '{24'd192,      16'd2};
    tbl[11] = '{-24'sd193,    -16'sd2};
    tbl[12] = '{24'd4194239,  16'd32767};
    tbl[13] = '{24'd4194240,  16'd32767};
    tbl[14] = '{-24'sd4194304, 16'h8000};
    tbl[15] = '{24'd0,        16'd0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst_hold");
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_vals("rst_release");

    // Transpose and first-column latency.
    out_ready = 1'b1;
    b0 = beats;
    for (int i = 0; i < 16; i++) send(24'(i * 128), conv(24'(i * 128)));
    chk("lat_one_cycle", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    chk("lat_two_cycles", {63'd0, out_valid}, 64'd1);
    chk("lat_col0", {62'd0, out_col}, 64'd0);
    chk("tr_first_lanes", {out_1, out_2, out_3, out_4}, {16'd0, 16'd4, 16'd8, 16'd12});
    drain("tr_drain");
    chk("tr_beats", 64'(beats - b0), 64'd4);

    // Rounding and saturation vectors.
    for (int i = 0; i < 16; i++) begin
      send(tbl[i].din, tbl[i].exp);
`ifdef IDCT_TRANSPOSE_SAT_FLAG_EN
      if (i == 4) chk("sat_before", {63'd0, sat_flag}, 64'd0);
      if (i == 5) chk("sat_rise", {63'd0, sat_flag}, 64'd1);
`endif
    end
    drain("vec_drain");
`ifdef IDCT_TRANSPOSE_SAT_FLAG_EN
    chk("sat_sticky", {63'd0, sat_flag}, 64'd1);
`endif

    // Backpressure with both banks full, then release.
    out_ready = 1'b0;
    acc_cnt   = 0;
    fork
      begin
        for (int i = 0; i < 48; i++) begin
          logic [23:0] d;
          d = 24'((i * 3001) - 60000);
          send(d, conv(d));
        end
      end
      begin
        int g;
        g = 0;
        while (acc_cnt < 32 && g < 500) begin
          @(negedge clk);
          g++;
        end
        chk("bp_fill_32", 64'(acc_cnt), 64'd32);
        repeat (3) @(negedge clk);
        #2;
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_hold_lanes_a", {out_1, out_2, out_3, out_4}, sb[0].lanes);
        chk("bp_hold_col", {61'd0, out_col, out_last}, 64'd0);
        repeat (4) @(negedge clk);
        #2;
        chk("bp_hold_lanes_b", {out_1, out_2, out_3, out_4}, sb[0].lanes);
        chk("bp_acc_stuck", 64'(acc_cnt), 64'd32);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        b0 = beats;
        for (int k = 1; k <= 8; k++) begin
          @(negedge clk);
          #2;
          if (k == 4) chk("bp_ready_at_col3", {63'd0, in_ready}, 64'd0);
          if (k == 5) chk("bp_ready_after_col3", {63'd0, in_ready}, 64'd1);
        end
        chk("bp_no_bubble", 64'(beats - b0), 64'd8);
      end
    join
    drain("bp_drain");

    // Back-to-back blocks with no backpressure.
    out_ready = 1'b1;
    low_cnt   = 0;
    b0 = beats;
    c0 = cyc;
    for (int i = 0; i < 32; i++) begin
      logic [23:0] d;
      d = 24'($urandom);
      if (i % 2 == 0) d = {{6{d[17]}}, d[17:0]};
      send(d, conv(d));
    end
    chk("b2b_cycles", 64'(cyc - c0), 64'd32);
    drain("b2b_drain");
    chk("b2b_in_ready_never_low", 64'(low_cnt), 64'd0);
    chk("b2b_beats", 64'(beats - b0), 64'd8);

    // Reset in the middle of a block.
    for (int i = 0; i < 7; i++) send(24'(1000 + i * 640), conv(24'(1000 + i * 640)));
    reset = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    blk_n = 0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    b0 = beats;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_no_output", {63'd0, out_valid}, 64'd0);
    for (int i = 0; i < 16; i++) send(24'(-5000 - i * 1280), conv(24'(-5000 - i * 1280)));
    drain("rst_drain");
    chk("rst_one_block", 64'(beats - b0), 64'd4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/idct_transpose_buf.md
Name: idct_transpose_buf

Overview:
- Downstream of the 1-D 4-point row IDCT stage. It consumes that stage's 24-bit serial results, one per cycle.
- Each sample is rounded, shifted and saturated to 16 bits, then written into a ping-pong 4x4 transpose memory.
- Complete blocks are read out one column per beat: four 16-bit lanes feed the second-pass (column) IDCT stage's d_in_1..d_in_4.

Parameters:
- SHIFT, 7: arithmetic right shift applied after rounding (first-pass IDCT scaling).
- IN_W, 24: input sample width (matches row-stage d_out).
- OUT_W, 16: output lane width (matches column-stage d_in_*).

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds a valid row-stage result.
- in_ready  output  1  buffer can accept a sample this cycle.
- in_data  input  IN_W  signed sample; row-major order within a block (r0c0, r0c1, ... r3c3).
- out_valid  output  1  out_1..out_4 hold a valid column.
- out_ready  input  1  downstream accepts the column this cycle.
- out_1..out_4  output  OUT_W each  signed column samples, rows 0..3 of the current column.
- out_col  output  2  column index of the current beat (0..3).
- out_last  output  1  high on the column-3 beat.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_1..4=0, out_col=0, out_last=0. Both banks EMPTY, write pointer = bank 0, write index 0, read FSM IDLE.
- Reset mid-operation: any partial or full block is discarded; there is no output after reset until 16 new samples are accepted.
- Conversion, per sample: t = (in_data + 2^(SHIFT-1)) >>> SHIFT, computed at IN_W+1 bits with no overflow. Saturate t to [-32768, 32767]. Registered into the bank memory at index (row = idx[3:2], col = idx[1:0]).
- Input accept: a sample is taken when in_valid && in_ready. in_ready = (write bank status == EMPTY).
- On the 16th accept: write bank becomes FULL, write pointer toggles, index wraps to 0.
- Read FSM IDLE: when the read bank is FULL, go to SEND next cycle with col=0.
- Read FSM SEND: out_valid=1; lanes are mem[rd][k][col] for k=0..3, registered.
  - On out_valid && out_ready: col increments.
  - On the col=3 handshake: read bank becomes EMPTY and the read pointer toggles. If the other bank is FULL, stay in SEND with col=0 (no bubble); else go to IDLE.
- Backpressure: outputs and col are held stable while out_valid && !out_ready.
- Latency: first column out_valid is asserted 2 cycles after the 16th sample is accepted.
- Sustained throughput: 1 sample/cycle in, 1 column per 4 cycles out (balanced).
- Simultaneous events: a write filling one bank and a read freeing the other bank in the same cycle are both applied. A bank freed on a cycle is writable (in_ready=1) the next cycle.

Optional Feature:
- Macro IDCT_TRANSPOSE_SAT_FLAG_EN.
- Defined: adds output sat_flag (1 bit). It is sticky and set on any accepted sample that saturated. Cleared only by reset, reset value 0.
- Undefined: no port, no saturation-detection logic; conversion behaviour is unchanged.

Decomposition:
- Shared package idct_pkg:
  - widths IN_W/OUT_W, SHIFT;
  - OUT_MAX=32767, OUT_MIN=-32768;
  - read FSM state encoding (IDLE, SEND);
  - bank status encoding (EMPTY, FULL).
- One natural sub-module: idct_round_sat (combinational round-shift-saturate, plus a saturation indicator), reused by the column-pass output stage.
- The memory banks and both FSMs stay in the top module.

Test Plan:
- Transpose: feed in_data = i*128 for i=0..15, out_ready=1 -> columns (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15); out_col 0..3; out_last only on the fourth beat.
- Rounding: in_data 8192 -> 64; 8256 -> 65 (8256+64=8320, 8320>>>7=65); -100 -> -1; -64 -> 0; 63 -> 0.
- Saturation: 0x7FFFFF -> 32767; 0x800000 -> -32768. With the macro defined, sat_flag rises after the first case and stays high.
- Backpressure and ping-pong:
  - Stream 48 samples continuously with out_ready=0 -> in_ready drops after sample 32; out_1..4 stay stable.
  - Then raise out_ready -> 12 columns emerge in order; in_ready returns 1 the cycle after block 0's column 3 handshake.
- Back-to-back: continuous input with out_ready=1 -> no bubble between block 0's column 3 and block 1's column 0; in_ready is never 0.
- Reset mid-block: assert reset after 7 samples -> outputs return to reset values. Then 16 fresh samples produce exactly one block with no stale data.
